// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state encoding
// and the fixed main-memory transfer size.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IC_RD,
        DC_RD,
        DC_WR,
        DONE
    } arb_state_t;

    localparam logic [1:0] MM_SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// Beat counter for one line burst.
// Ports: MEM_CLK, RST, clear (restart at 0), inc (beat done),
//        beat (current index), last (beat == N-1).
module burst_counter #(
    parameter int N = 8
) (
    input  logic                 MEM_CLK,
    input  logic                 RST,
    input  logic                 clear,
    input  logic                 inc,
    output logic [$clog2(N)-1:0] beat,
    output logic                 last
);

    localparam int BW = $clog2(N);

    always_ff @(posedge MEM_CLK or posedge RST) begin
        if (RST)
            beat <= '0;
        else if (clear)
            beat <= '0;
        else if (inc)
            beat <= beat + 1'b1;
    end

    assign last = (beat == BW'(N - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing main memory between the I- and
// D-cache for whole-line bursts (IC fill, DC fill, DC writeback).
// Ports: MEM_CLK/RST; IC_* and DC_* requester sides (req, addr,
//        grant, beat strobes, data, done); MM_* memory command side.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              MEM_CLK,
    input  logic              RST,
    input  logic              IC_REQ,
    input  logic [ADDR_W-1:0] IC_ADDR,
    output logic              IC_GNT,
    output logic              IC_DVALID,
    output logic              IC_DONE,
    output logic [31:0]       IC_DATA,
    input  logic              DC_REQ,
    input  logic              DC_WE,
    input  logic [ADDR_W-1:0] DC_ADDR,
    input  logic [31:0]       DC_WDATA,
    output logic              DC_GNT,
    output logic              DC_DVALID,
    output logic              DC_WREADY,
    output logic              DC_DONE,
    output logic [31:0]       DC_DATA,
    output logic              MM_RDEN,
    output logic              MM_WE,
    output logic [ADDR_W-1:0] MM_ADDR,
    output logic [31:0]       MM_DIN,
    output logic [1:0]        MM_SIZE,
    input  logic [31:0]       MM_DOUT,
    input  logic              MM_VALID
);

    localparam int BW    = $clog2(LINE_WORDS);
    localparam int OFF_W = BW + 2;
    localparam logic [ADDR_W-1:0] OFF_MASK =
        ADDR_W'((1 << OFF_W) - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [ADDR_W-1:0] base;
    logic              owner_dc;
    // 1 = DC held the bus last, so IC wins the next tie.
    logic              last_gnt_dc;
    logic              grant;
    logic              pick_dc;
    logic              active;
    logic              beat_done;
    logic [BW-1:0]     beat;
    logic              beat_last;

    assign active    = (state == IC_RD) || (state == DC_RD)
                    || (state == DC_WR);
    assign beat_done = active && MM_VALID;

    burst_counter #(
        .N (LINE_WORDS)
    ) u_cnt (
        .MEM_CLK (MEM_CLK),
        .RST     (RST),
        .clear   (grant),
        .inc     (beat_done),
        .beat    (beat),
        .last    (beat_last)
    );

    always_ff @(posedge MEM_CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        pick_dc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (IC_REQ || DC_REQ) begin
                    grant   = 1'b1;
                    pick_dc = (IC_REQ && DC_REQ) ? !last_gnt_dc
                                                 : DC_REQ;
                    if (!pick_dc)
                        state_nxt = IC_RD;
                    else if (DC_WE)
                        state_nxt = DC_WR;
                    else
                        state_nxt = DC_RD;
                end
            end
            IC_RD, DC_RD, DC_WR: begin
                if (MM_VALID && beat_last)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge MEM_CLK or posedge RST) begin
        if (RST) begin
            base        <= '0;
            owner_dc    <= 1'b0;
            last_gnt_dc <= 1'b1;
        end else begin
            if (grant) begin
                base     <= (pick_dc ? DC_ADDR : IC_ADDR) & ~OFF_MASK;
                owner_dc <= pick_dc;
            end
            if (state == DONE)
                last_gnt_dc <= owner_dc;
        end
    end

    assign IC_GNT    = (state != IDLE) && !owner_dc;
    assign DC_GNT    = (state != IDLE) && owner_dc;
    assign IC_DVALID = (state == IC_RD) && MM_VALID;
    assign DC_DVALID = (state == DC_RD) && MM_VALID;
    assign DC_WREADY = (state == DC_WR) && MM_VALID;
    assign IC_DONE   = (state == DONE) && !owner_dc;
    assign DC_DONE   = (state == DONE) && owner_dc;
    assign IC_DATA   = IC_DVALID ? MM_DOUT : 32'h0;
    assign DC_DATA   = DC_DVALID ? MM_DOUT : 32'h0;

    assign MM_RDEN = (state == IC_RD) || (state == DC_RD);
    assign MM_WE   = (state == DC_WR);
    assign MM_ADDR = base
                   + {{(ADDR_W - BW - 2){1'b0}}, beat, 2'b00};
    assign MM_DIN  = MM_WE ? DC_WDATA : 32'h0;
    assign MM_SIZE = MM_SIZE_WORD;

endmodule
